wishbone_bus_bridge: RTL and testbench

Parametrised bridge that turns the core's single-cycle memory port (ce/addr/data/we/sel) into a registered, multi-cycle Wishbone B4 classic master cycle. It sits between a pipeline access point and the system bus: the instruction fetch port with `STALL_BIT=1` or the MEM-stage data port with `STALL_BIT=3`. It raises a stall request while the bus transaction is in flight. It honours pipeline stall and flush, and it adds a configurable bus-error/timeout termination that the single-cycle port does not have.

---
 rtl/wishbone_bus_bridge.sv | 177 +++++++++++++++++
 tb/tb_wishbone_bus_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_bridge.sv
// Bridge from the core's single-cycle memory port to a registered Wishbone B4 classic
// master cycle. It holds the pipeline with a stall request while the cycle is in flight,
// aborts on flush, and ends a cycle with an error on bus err or timeout.
module wishbone_bus_bridge #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STALL_BIT = 3,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned SEL_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_we_i,
    input  logic [SEL_W-1:0]  cpu_sel_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    // Counter only needs to reach TIMEOUT-1; TIMEOUT of 0 or 1 still gets a 1-bit counter.
    localparam int unsigned     CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StWaitStall
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wb_adr_q, wb_adr_d;
    logic [DATA_W-1:0]  wb_dat_q, wb_dat_d;
    logic [SEL_W-1:0]   wb_sel_q, wb_sel_d;
    logic               wb_we_q, wb_we_d;
    logic               wb_stb_q, wb_stb_d;
    logic               wb_cyc_q, wb_cyc_d;
    logic               bus_err_q, bus_err_d;
    logic [DATA_W-1:0]  rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               stall_any;
    logic               timeout_hit;
    logic               req;

    // STALL_BIT only documents how ctrl wires this bridge; any stall bit freezes it.
    logic               unused_stall_bit;
    assign unused_stall_bit = (STALL_BIT < STALL_W);

    assign stall_any   = |stall_i;
    assign req         = cpu_ce_i && !flush_i;
    assign timeout_hit = (state_q == StBusy) && (TIMEOUT != 0) && (cnt_q == CntMax);

    // State and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wb_adr_q  <= '0;
            wb_dat_q  <= '0;
            wb_sel_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_stb_q  <= 1'b0;
            wb_cyc_q  <= 1'b0;
            bus_err_q <= 1'b0;
            rd_buf_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wb_adr_q  <= wb_adr_d;
            wb_dat_q  <= wb_dat_d;
            wb_sel_q  <= wb_sel_d;
            wb_we_q   <= wb_we_d;
            wb_stb_q  <= wb_stb_d;
            wb_cyc_q  <= wb_cyc_d;
            bus_err_q <= bus_err_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic plus the combinational stall request and read-data path.
    always_comb begin
        state_d    = state_q;
        wb_adr_d   = wb_adr_q;
        wb_dat_d   = wb_dat_q;
        wb_sel_d   = wb_sel_q;
        wb_we_d    = wb_we_q;
        wb_stb_d   = wb_stb_q;
        wb_cyc_d   = wb_cyc_q;
        bus_err_d  = 1'b0;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        stallreq_o = 1'b0;
        cpu_data_o = '0;

        unique case (state_q)
            StIdle: begin
                stallreq_o = req;
                cpu_data_o = rd_buf_q;
                if (req) begin
                    wb_adr_d = cpu_addr_i;
                    wb_dat_d = cpu_data_i;
                    wb_sel_d = cpu_sel_i;
                    wb_we_d  = cpu_we_i;
                    wb_stb_d = 1'b1;
                    wb_cyc_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end

            StBusy: begin
                stallreq_o = !(wb_ack_i || wb_err_i || timeout_hit);
                if (wb_ack_i && !wb_we_q) begin
                    cpu_data_o = wb_dat_i;
                end
                if (flush_i) begin
                    wb_stb_d = 1'b0;
                    wb_cyc_d = 1'b0;
                    wb_we_d  = 1'b0;
                    state_d  = StIdle;
                end else if (wb_ack_i) begin
                    // Ack beats a simultaneous err.
                    wb_stb_d = 1'b0;
                    wb_cyc_d = 1'b0;
                    if (!wb_we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                    state_d = stall_any ? StWaitStall : StIdle;
                end else if (wb_err_i || timeout_hit) begin
                    wb_stb_d  = 1'b0;
                    wb_cyc_d  = 1'b0;
                    rd_buf_d  = '0;
                    bus_err_d = 1'b1;
                    state_d   = stall_any ? StWaitStall : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StWaitStall: begin
                // Parked so a still-asserted ce does not re-issue the finished access.
                cpu_data_o = rd_buf_q;
                if (!stall_any || flush_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wb_adr_o  = wb_adr_q;
    assign wb_dat_o  = wb_dat_q;
    assign wb_sel_o  = wb_sel_q;
    assign wb_we_o   = wb_we_q;
    assign wb_stb_o  = wb_stb_q;
    assign wb_cyc_o  = wb_cyc_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wishbone_bus_bridge.sv
// Self-checking bench for wishbone_bus_bridge: table-driven single transactions with a
// queue of expected read data, plus hand sequences for stall parking, flush and reset.
module tb_wishbone_bus_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    wishbone_bus_bridge #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .STALL_W  (6),
        .STALL_BIT(3),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .cpu_ce_i  (cpu_ce_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o),
        .bus_err_o (bus_err_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    always #5 clk = ~clk;

    // resp: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout)
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdata;
        int          resp;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] exp_q[$];
    logic [31:0] rd_model;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_ce_i = 1'b0;
        flush_i  = 1'b0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
    endtask

    // One full transaction: request cycle, BUSY cycles up to termination, two idle cycles.
    task automatic run_vec(input vec_t v);
        int          term;
        int          stalls;
        logic        exp_err;
        logic [31:0] exp_d;
        term    = (v.resp == 3) ? TO : v.waits + 1;
        exp_err = (v.resp == 1 || v.resp == 3);
        exp_d   = (!exp_err && !v.we) ? v.rdata : 32'h0;
        exp_q.push_back(exp_d);

        @(negedge clk);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = v.addr;
        cpu_data_i = v.wdata;
        cpu_we_i   = v.we;
        cpu_sel_i  = v.sel;
        #1;
        stalls = stallreq_o ? 1 : 0;
        for (int k = 1; k <= term; k++) begin
            @(negedge clk);
            wb_ack_i = (k == term) && (v.resp == 0 || v.resp == 2);
            wb_err_i = (k == term) && (v.resp == 1 || v.resp == 2);
            wb_dat_i = (k == term) ? v.rdata : 32'hFFFF_FFFF;
            #1;
            check("stb_cyc", 32'(wb_stb_o && wb_cyc_o), 32'd1);
            check("adr", wb_adr_o, v.addr);
            check("dat_o", wb_dat_o, v.wdata);
            check("sel", 32'(wb_sel_o), 32'(v.sel));
            check("we", 32'(wb_we_o), 32'(v.we));
            check("busy_err", 32'(bus_err_o), 32'd0);
            if (stallreq_o) stalls++;
            if (k == term) check("term_data", cpu_data_o, exp_q.pop_front());
        end

        if (exp_err) rd_model = 32'h0;
        else if (!v.we) rd_model = v.rdata;

        @(negedge clk);
        idle_inputs();
        #1;
        check("post_stb", 32'(wb_stb_o), 32'd0);
        check("post_cyc", 32'(wb_cyc_o), 32'd0);
        check("err_pulse", 32'(bus_err_o), 32'(exp_err));
        check("rd_buf", cpu_data_o, rd_model);
        check("post_stallreq", 32'(stallreq_o), 32'd0);
        check("stall_cycles", 32'(stalls), 32'(term));
        @(negedge clk);
        #1;
        check("err_one_cycle", 32'(bus_err_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nstb;
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,          4'hF, 0, 32'hDEAD_BEEF, 0};
        vecs[1] = '{1'b1, 32'h0000_0200, 32'h1234_5678,  4'b0011, 3, 32'hFEED_FACE, 0};
        vecs[2] = '{1'b0, 32'h0000_0204, 32'h0,          4'hF, 1, 32'hCAFE_F00D, 0};
        vecs[3] = '{1'b0, 32'h0000_0300, 32'h0,          4'hF, 2, 32'h5555_5555, 1};
        vecs[4] = '{1'b0, 32'h0000_0304, 32'h0,          4'hF, 0, 32'hA5A5_5A5A, 0};
        vecs[5] = '{1'b0, 32'h0000_0308, 32'h0,          4'hF, 0, 32'h9999_9999, 3};
        vecs[6] = '{1'b0, 32'h0000_030C, 32'h0,          4'hF, 1, 32'h1122_3344, 2};
        vecs[7] = '{1'b1, 32'h0000_0400, 32'hAAAA_0000,  4'b1100, 0, 32'h7777_0000, 0};
        vecs[8] = '{1'b0, 32'h0000_0404, 32'h0,          4'hF, 2, 32'h0BAD_C0DE, 0};

        rst        = 1'b1;
        stall_i    = 6'h0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'h0;
        idle_inputs();
        rd_model   = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_err", 32'(bus_err_o), 32'd0);
        check("rst_data", cpu_data_o, 32'h0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Ack while another stall source holds the pipeline: park, no re-issue.
        nstb = 0;
        @(negedge clk);
        stall_i    = 6'b000111;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0000_0500;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'hF;
        @(negedge clk);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h7777_7777;
        #1;
        if (wb_stb_o) nstb++;
        check("ws_ack_data", cpu_data_o, 32'h7777_7777);
        check("ws_ack_stallreq", 32'(stallreq_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_dat_i = 32'h0;
            #1;
            if (wb_stb_o) nstb++;
            check("ws_stallreq", 32'(stallreq_o), 32'd0);
            check("ws_hold", cpu_data_o, 32'h7777_7777);
        end
        @(negedge clk);
        stall_i  = 6'h0;
        cpu_ce_i = 1'b0;
        #1;
        if (wb_stb_o) nstb++;
        @(negedge clk);
        #1;
        if (wb_stb_o) nstb++;
        check("ws_one_cycle", 32'(nstb), 32'd1);
        check("ws_idle_data", cpu_data_o, 32'h7777_7777);
        rd_model = 32'h7777_7777;
        run_vec(vecs[4]);

        // Flush in the second BUSY cycle of a write.
        @(negedge clk);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0000_0600;
        cpu_data_i = 32'hBBBB_CCCC;
        cpu_we_i   = 1'b1;
        cpu_sel_i  = 4'hF;
        @(negedge clk);
        #1;
        check("fl_busy1_stb", 32'(wb_stb_o), 32'd1);
        @(negedge clk);
        flush_i  = 1'b1;
        cpu_ce_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("fl_stb", 32'(wb_stb_o), 32'd0);
        check("fl_cyc", 32'(wb_cyc_o), 32'd0);
        check("fl_we", 32'(wb_we_o), 32'd0);
        check("fl_err", 32'(bus_err_o), 32'd0);
        check("fl_rd_buf", cpu_data_o, rd_model);
        @(negedge clk);
        #1;
        check("fl_err_late", 32'(bus_err_o), 32'd0);

        // Request masked by flush in IDLE.
        @(negedge clk);
        cpu_ce_i = 1'b1;
        flush_i  = 1'b1;
        #1;
        check("fl_idle_stallreq", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("fl_idle_stb", 32'(wb_stb_o), 32'd0);

        // Synchronous reset in the middle of a read.
        @(negedge clk);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0000_0700;
        cpu_data_i = 32'h1357_9BDF;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'hF;
        @(negedge clk);
        cpu_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_stb", 32'(wb_stb_o), 32'd0);
        check("mr_cyc", 32'(wb_cyc_o), 32'd0);
        check("mr_adr", wb_adr_o, 32'h0);
        check("mr_dat", wb_dat_o, 32'h0);
        check("mr_sel", 32'(wb_sel_o), 32'd0);
        check("mr_err", 32'(bus_err_o), 32'd0);
        check("mr_data", cpu_data_o, 32'h0);
        check("mr_stallreq", 32'(stallreq_o), 32'd0);
        rd_model = 32'h0;
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
